alu_arbiter: RTL

Shares the single RV32I `ALU` instance between two requesters, such as the integer execute path and the branch-compare path. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates between the two requesters, registers the winner's operands and drives them into the `ALU` for one cycle. It then captures Result and flags and holds them until the owning requester accepts them. Only one transaction is in flight at a time.

---
 rtl/alu_arbiter.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one RV32I ALU between two requesters. Each requester has a
//   valid/ready request channel and a valid/ready response channel.
//   The block arbitrates between the requesters and registers the winner's
//   operands. It drives them through the ALU for one cycle, then holds the
//   captured result and flags until the owning port accepts them.
//   Only one transaction is in flight at a time.
//
// Parameters
//   RR_ENABLE   1 = round-robin between ports, 0 = fixed priority (port 0 wins)
//
// Ports (N = 0, 1)
//   clk, rst        clock, asynchronous active-high reset
//   reqN_valid      request from port N
//   reqN_ready      request accepted this cycle (combinational, IDLE only)
//   reqN_a/_b/_op   operands and ALUControl code
//   rspN_valid      response available for port N
//   rspN_ready      port N consumes the response
//   rspN_result     ALU result (registered)
//   rspN_flags      {Carry, OverFlow, Zero, Negative} (registered)
//   rspN_err        opcode was illegal (1010-1111) (registered)
// -----------------------------------------------------------------------------

// RV32I ALU: purely combinational result and flag generation.
module alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic        carry_s;
    logic        ovf_s;

    // Operation select; carry and overflow are meaningful for ADD/SUB only.
    always_comb begin
        sum_s    = {1'b0, a_i} + {1'b0, b_i};
        diff_s   = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
        result_o = 32'd0;
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (op_i)
            4'd0: begin
                result_o = sum_s[31:0];
                carry_s  = sum_s[32];
                ovf_s    = (a_i[31] == b_i[31]) && (sum_s[31] != a_i[31]);
            end
            4'd1: begin
                result_o = diff_s[31:0];
                carry_s  = diff_s[32];
                ovf_s    = (a_i[31] != b_i[31]) && (diff_s[31] != a_i[31]);
            end
            4'd2:    result_o = a_i & b_i;
            4'd3:    result_o = a_i | b_i;
            4'd4:    result_o = a_i ^ b_i;
            4'd5:    result_o = {31'd0, ($signed(a_i) < $signed(b_i))};
            4'd6:    result_o = {31'd0, (a_i < b_i)};
            4'd7:    result_o = a_i << b_i[4:0];
            4'd8:    result_o = a_i >> b_i[4:0];
            4'd9:    result_o = $signed(a_i) >>> b_i[4:0];
            default: result_o = 32'd0;
        endcase
        flags_o = {carry_s, ovf_s, (result_o == 32'd0), result_o[31]};
    end
endmodule

module alu_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [3:0]  rsp0_flags,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [3:0]  rsp1_flags,
    output logic        rsp1_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [31:0] rsp0_result_q, rsp0_result_d;
    logic [3:0]  rsp0_flags_q, rsp0_flags_d;
    logic        rsp0_err_q, rsp0_err_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [31:0] rsp1_result_q, rsp1_result_d;
    logic [3:0]  rsp1_flags_q, rsp1_flags_d;
    logic        rsp1_err_q, rsp1_err_d;

    logic        grant0_s;
    logic        grant1_s;
    logic [31:0] alu_result_s;
    logic [3:0]  alu_flags_s;
    logic        illegal_s;
    logic [31:0] cap_result_s;
    logic [3:0]  cap_flags_s;

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result_s),
        .flags_o  (alu_flags_s)
    );

    // Winner selection. Under round-robin, port 1 wins a tie only when
    // port 0 was the last port served; a lone valid port always wins.
    always_comb begin
        if (RR_ENABLE) begin
            grant1_s = req1_valid && (!req0_valid || (last_grant_q == 1'b0));
        end else begin
            grant1_s = req1_valid && !req0_valid;
        end
        grant0_s = req0_valid && !grant1_s;
    end

    assign req0_ready = (state_q == IDLE) && grant0_s;
    assign req1_ready = (state_q == IDLE) && grant1_s;

    // Illegal opcodes bypass the ALU with a zero result and only Zero set.
    assign illegal_s    = (op_q > 4'd9);
    assign cap_result_s = illegal_s ? 32'd0 : alu_result_s;
    assign cap_flags_s  = illegal_s ? 4'b0010 : alu_flags_s;

    // Next-state and datapath-load logic for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_flags_d  = rsp0_flags_q;
        rsp0_err_d    = rsp0_err_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_flags_d  = rsp1_flags_q;
        rsp1_err_d    = rsp1_err_q;
        case (state_q)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    owner_d = grant1_s;
                    a_d     = grant1_s ? req1_a  : req0_a;
                    b_d     = grant1_s ? req1_b  : req0_b;
                    op_d    = grant1_s ? req1_op : req0_op;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    rsp1_valid_d  = 1'b1;
                    rsp1_result_d = cap_result_s;
                    rsp1_flags_d  = cap_flags_s;
                    rsp1_err_d    = illegal_s;
                end else begin
                    rsp0_valid_d  = 1'b1;
                    rsp0_result_d = cap_result_s;
                    rsp0_flags_d  = cap_flags_s;
                    rsp0_err_d    = illegal_s;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            a_q           <= 32'd0;
            b_q           <= 32'd0;
            op_q          <= 4'd0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 32'd0;
            rsp0_flags_q  <= 4'd0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 32'd0;
            rsp1_flags_q  <= 4'd0;
            rsp1_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_flags_q  <= rsp0_flags_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_flags_q  <= rsp1_flags_d;
            rsp1_err_q    <= rsp1_err_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_flags  = rsp0_flags_q;
    assign rsp0_err    = rsp0_err_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_flags  = rsp1_flags_q;
    assign rsp1_err    = rsp1_err_q;
endmodule
